// File: rtl/ysyx_23060096_regfile_2w2r.sv
// Purpose: two-write, two-read GPR file for the NPC core, with a post-reset sequential clear.
// Latency: reads are combinational (0 cycles); writes land at the next rising clk edge.
// Backpressure: none; ready=0 while clearing, and writes presented then are dropped.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   w0_en/addr/data   write port 0 (execute/writeback)
//   w1_en/addr/data   write port 1 (load return); wins over w0 on an index collision
//   Ra/Rb -> busA/busB  combinational read ports
//   ready             1 once the clear has swept every entry
//   clr_idx           current clear index (debug); holds DEPTH-1 once running
// Optional feature: define YSYX_23060096_RF_BYPASS_EN for same-cycle write-to-read forwarding.
module ysyx_23060096_regfile_2w2r #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w0_en,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  input  logic                  w1_en,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  input  logic [ADDR_WIDTH-1:0] Ra,
  input  logic [ADDR_WIDTH-1:0] Rb,
  output logic [DATA_WIDTH-1:0] busA,
  output logic [DATA_WIDTH-1:0] busB,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] clr_idx
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = 1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_q;
  logic [DATA_WIDTH-1:0] rf [DEPTH];

  logic w0_ok;
  logic w1_ok;

  // Index 0 is a hardwired zero when ZERO_REG is set: writes to it are dropped.
  assign w0_ok = w0_en && !((ZERO_REG != 0) && (w0_addr == '0));
  assign w1_ok = w1_en && !((ZERO_REG != 0) && (w1_addr == '0));

  // Control: reset always restarts the sweep from index 0; the last index
  // is cleared in the same cycle the FSM moves to RUN, so clr_q never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      clr_q <= '0;
    end else if (state == CLEAR) begin
      if (clr_q == LAST_IDX) begin
        state <= RUN;
      end else begin
        clr_q <= clr_q + IDX_ONE;
      end
    end
  end

  // Storage: reset itself leaves contents alone; only the sweep zeroes them.
  // w1 is written after w0 so that on a same-index collision w1's value sticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        rf[clr_q] <= '0;
      end else begin
        if (w0_ok) rf[w0_addr] <= w0_data;
        if (w1_ok) rf[w1_addr] <= w1_data;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = rf[idx];
`ifdef YSYX_23060096_RF_BYPASS_EN
    // Forward this cycle's write data; w1 checked last so it has priority.
    if (w0_en && (w0_addr == idx)) val = w0_data;
    if (w1_en && (w1_addr == idx)) val = w1_data;
`endif
    if (state != RUN) val = '0;
    if ((ZERO_REG != 0) && (idx == '0)) val = '0;
    return val;
  endfunction

  always_comb begin
    busA = read_port(Ra);
    busB = read_port(Rb);
  end

  assign ready   = (state == RUN);
  assign clr_idx = clr_q;

endmodule

// File: tb/tb_ysyx_23060096_regfile_2w2r.sv
module tb_ysyx_23060096_regfile_2w2r;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w0_en = 1'b0, w1_en = 1'b0;
  logic [4:0]  w0_addr = '0, w1_addr = '0, Ra = '0, Rb = '0;
  logic [31:0] w0_data = '0, w1_data = '0;

  logic [31:0] busA_z, busB_z, busA_n, busB_n;
  logic        ready_z, ready_n;
  logic [4:0]  clr_idx_z, clr_idx_n;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ysyx_23060096_regfile_2w2r #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) u_z (
    .clk(clk), .rst(rst),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .Ra(Ra), .Rb(Rb), .busA(busA_z), .busB(busB_z),
    .ready(ready_z), .clr_idx(clr_idx_z)
  );

  ysyx_23060096_regfile_2w2r #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) u_n (
    .clk(clk), .rst(rst),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .Ra(Ra), .Rb(Rb), .busA(busA_n), .busB(busB_n),
    .ready(ready_n), .clr_idx(clr_idx_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // After reset the file is "clearing" for 32 cycles, then every entry is 0.
  bit          started = 0;
  int          done    = 0;      // clear cycles completed since last reset
  logic [31:0] mz [32];          // contents, ZERO_REG=1 instance
  logic [31:0] mn [32];          // contents, ZERO_REG=0 instance

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      done    = 0;
    end else if (started) begin
      if (done < 32) begin
        done++;
        if (done == 32)
          for (int i = 0; i < 32; i++) begin mz[i] = '0; mn[i] = '0; end
      end else begin
        if (w0_en) begin mn[w0_addr] = w0_data; if (w0_addr != 0) mz[w0_addr] = w0_data; end
        if (w1_en) begin mn[w1_addr] = w1_data; if (w1_addr != 0) mz[w1_addr] = w1_data; end
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit zr);
    if (done != 32) return '0;
    if (zr && idx == 0) return '0;
`ifdef YSYX_23060096_RF_BYPASS_EN
    if (w1_en && w1_addr == idx) return w1_data;
    if (w0_en && w0_addr == idx) return w0_data;
`endif
    return zr ? mz[idx] : mn[idx];
  endfunction

  // Single compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (started) begin
      chk("ready_z",   {31'd0, ready_z}, {31'd0, done == 32});
      chk("ready_n",   {31'd0, ready_n}, {31'd0, done == 32});
      chk("clr_idx_z", {27'd0, clr_idx_z}, (done == 32) ? 32'd31 : done);
      chk("clr_idx_n", {27'd0, clr_idx_n}, (done == 32) ? 32'd31 : done);
      chk("busA_z", busA_z, exp_rd(Ra, 1));
      chk("busB_z", busB_z, exp_rd(Rb, 1));
      chk("busA_n", busA_n, exp_rd(Ra, 0));
      chk("busB_n", busB_n, exp_rd(Rb, 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w0_en = 0; w1_en = 0;
  endtask

  initial begin
    // Clear sequence: rst high for 2 cycles.
    step(); step();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      Ra = 5'($urandom); Rb = 5'($urandom);
      #1;
      chk("clear_idx_lit", {27'd0, clr_idx_z}, i);
      chk("clear_ready_lit", {31'd0, ready_z}, 32'd0);
      chk("clear_bus_lit", busA_n, 32'd0);
      step();
    end
    chk("ready_after_32", {31'd0, ready_z}, 32'd1);
    chk("clr_idx_hold", {27'd0, clr_idx_n}, 32'd31);
    for (int i = 0; i < 32; i++) begin
      Ra = 5'(i); Rb = 5'(31 - i);
      #1;
      chk("cleared_A", busA_n, 32'd0);
      chk("cleared_B", busB_n, 32'd0);
    end

    // Basic write/read (and bypass visibility before the edge).
    w0_en = 1; w0_addr = 5; w0_data = 32'hDEADBEEF; Ra = 5; Rb = 5;
    #1;
`ifdef YSYX_23060096_RF_BYPASS_EN
    chk("x5_pre_edge", busA_z, 32'hDEADBEEF);
`else
    chk("x5_pre_edge", busA_z, 32'h0);
`endif
    step(); idle();
    #1;
    chk("x5_busA", busA_z, 32'hDEADBEEF);
    chk("x5_busB", busB_z, 32'hDEADBEEF);

    // Collision: w1 wins; then disjoint dual write.
    w0_en = 1; w0_addr = 7; w0_data = 32'h11111111;
    w1_en = 1; w1_addr = 7; w1_data = 32'h22222222;
    step();
    w0_addr = 8; w0_data = 32'h3; w1_addr = 9; w1_data = 32'h4;
    step(); idle();
    Ra = 7; Rb = 8; #1;
    chk("x7_collision", busA_n, 32'h22222222);
    chk("x8_dual", busB_n, 32'h3);
    Ra = 9; #1;
    chk("x9_dual", busA_n, 32'h4);

    // Zero register.
    w1_en = 1; w1_addr = 0; w1_data = 32'hFFFFFFFF;
    step(); idle();
    Ra = 0; Rb = 0; #1;
    chk("x0_zero_reg1", busA_z, 32'h0);
    chk("x0_zero_reg0", busA_n, 32'hFFFFFFFF);

    // Bypass on x4.
    w0_en = 1; w0_addr = 4; w0_data = 32'h12345678; Ra = 4; #1;
`ifdef YSYX_23060096_RF_BYPASS_EN
    chk("x4_bypass", busA_z, 32'h12345678);
`else
    chk("x4_no_bypass", busA_z, 32'h0);
`endif
    step(); idle(); #1;
    chk("x4_after_edge", busA_z, 32'h12345678);

    // Randomized traffic; compare process checks every cycle.
    for (int c = 0; c < 400; c++) begin
      w0_en = 1'($urandom); w0_addr = 5'($urandom); w0_data = $urandom;
      w1_en = 1'($urandom); w1_addr = 5'($urandom); w1_data = $urandom;
      if ($urandom_range(0, 3) == 0) w1_addr = w0_addr;
      Ra = 5'($urandom); Rb = ($urandom_range(0, 3) == 0) ? Ra : 5'($urandom);
      step();
    end
    idle();

    // Reset in RUN, then reset again at clear cycle 10, with w0 hammering x3.
    rst = 1; step(); rst = 0;
    w0_en = 1; w0_addr = 3; w0_data = 32'hA5; Ra = 3; Rb = 3;
    for (int i = 0; i < 10; i++) step();
    chk("mid_clear_idx", {27'd0, clr_idx_z}, 32'd10);
    rst = 1; step();
    chk("restart_idx", {27'd0, clr_idx_z}, 32'd0);
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("reclear_ready", {31'd0, ready_n}, 32'd0);
      chk("reclear_bus", busA_n, 32'd0);
      w0_data = $urandom;
      step();
    end
    idle();
    #1;
    chk("reclear_done", {31'd0, ready_n}, 32'd1);
    chk("x3_blocked", busA_n, 32'h0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
